// File: rtl/ldm_read_agu_if.sv
// ldm_read_agu_if: sequencer-side config/handshake and LSU-side CTRL_LDM request bundle
interface ldm_read_agu_if #(
  parameter int S_LDM_BITS    = 2,
  parameter int LDM_ADDR_BITS = 6,
  parameter int PAD_BITS      = 3
);
  logic                                start_in;
  logic                                stall_in;
  logic [S_LDM_BITS-1:0]               cfg_bank_a_in;
  logic [LDM_ADDR_BITS-1:0]            cfg_base_a_in;
  logic [S_LDM_BITS-1:0]               cfg_bank_b_in;
  logic [LDM_ADDR_BITS-1:0]            cfg_base_b_in;
  logic                                cfg_dual_in;
  logic [LDM_ADDR_BITS:0]              cfg_len_in;
  logic [LDM_ADDR_BITS-1:0]            cfg_stride_in;
  logic [PAD_BITS-1:0]                 cfg_pad_pre_in;
  logic [PAD_BITS-1:0]                 cfg_pad_post_in;
  logic [S_LDM_BITS+LDM_ADDR_BITS-1:0] CTRL_LDM_addra_out;
  logic                                CTRL_LDM_ena_out;
  logic                                CTRL_LDM_wea_out;
  logic [S_LDM_BITS+LDM_ADDR_BITS-1:0] CTRL_LDM_addrb_out;
  logic                                CTRL_LDM_enb_out;
  logic                                CTRL_LDM_web_out;
  logic                                Padding_Read_out;
  logic                                busy_out;
  logic                                last_out;
  logic                                done_out;
  modport master (
    output start_in, stall_in, cfg_bank_a_in, cfg_base_a_in, cfg_bank_b_in, cfg_base_b_in,
           cfg_dual_in, cfg_len_in, cfg_stride_in, cfg_pad_pre_in, cfg_pad_post_in,
    input  CTRL_LDM_addra_out, CTRL_LDM_ena_out, CTRL_LDM_wea_out, CTRL_LDM_addrb_out,
           CTRL_LDM_enb_out, CTRL_LDM_web_out, Padding_Read_out, busy_out, last_out, done_out
  );
  modport slave (
    input  start_in, stall_in, cfg_bank_a_in, cfg_base_a_in, cfg_bank_b_in, cfg_base_b_in,
           cfg_dual_in, cfg_len_in, cfg_stride_in, cfg_pad_pre_in, cfg_pad_post_in,
    output CTRL_LDM_addra_out, CTRL_LDM_ena_out, CTRL_LDM_wea_out, CTRL_LDM_addrb_out,
           CTRL_LDM_enb_out, CTRL_LDM_web_out, Padding_Read_out, busy_out, last_out, done_out
  );
endinterface

// File: rtl/ldm_read_agu.sv
// ldm_read_agu: replays a padded, strided LDM read sequence onto the LSU CTRL_LDM ports
module ldm_read_agu #(
  parameter int S_LDM_BITS    = 2,
  parameter int LDM_ADDR_BITS = 6,
  parameter int PAD_BITS      = 3
) (
  input logic          CLK,
  input logic          RST,
  ldm_read_agu_if.slave bus
);
  localparam int AW = S_LDM_BITS + LDM_ADDR_BITS;
  localparam int CW = LDM_ADDR_BITS + 1;
  typedef enum logic [2:0] {IDLE, PAD_PRE, READ, PAD_POST, DONE} state_t;
  state_t                   state_q, state_d, nxt;
  logic [CW-1:0]            cnt_q, cnt_d, lim, len_q, e_len;
  logic [LDM_ADDR_BITS-1:0] ptr_a_q, ptr_a_d, ptr_b_q, ptr_b_d, stride_q;
  logic [LDM_ADDR_BITS-1:0] e_ptr_a, e_ptr_b, e_stride;
  logic [S_LDM_BITS-1:0]    bank_a_q, bank_b_q, e_bank_a, e_bank_b;
  logic [PAD_BITS-1:0]      pre_q, post_q, e_pre, e_post;
  logic                     dual_q, e_dual;
  logic [AW-1:0]            addra_q, addra_d, addrb_q, addrb_d;
  logic                     ena_q, ena_d, enb_q, enb_d, pad_q, pad_d, busy_q, busy_d, done_q, done_d;
  logic                     idle, ld, run, fin, iss, rd, more;
  // In IDLE the live cfg inputs stand in for the latched copy so the first slot issues on the start edge
  always_comb begin
    idle     = state_q == IDLE;
    e_bank_a = idle ? bus.cfg_bank_a_in : bank_a_q;
    e_bank_b = idle ? bus.cfg_bank_b_in : bank_b_q;
    e_ptr_a  = idle ? bus.cfg_base_a_in : ptr_a_q;
    e_ptr_b  = idle ? bus.cfg_base_b_in : ptr_b_q;
    e_stride = idle ? bus.cfg_stride_in : stride_q;
    e_dual   = idle ? bus.cfg_dual_in : dual_q;
    e_len    = idle ? bus.cfg_len_in : len_q;
    e_pre    = idle ? bus.cfg_pad_pre_in : pre_q;
    e_post   = idle ? bus.cfg_pad_post_in : post_q;
    lim      = state_q == PAD_PRE ? CW'(e_pre) : state_q == READ ? e_len :
               state_q == PAD_POST ? CW'(e_post) : '0;
    more     = cnt_q < lim;
    nxt      = more ? state_q :
               (idle && e_pre != '0) ? PAD_PRE :
               ((idle || state_q == PAD_PRE) && e_len != '0) ? READ :
               (state_q != PAD_POST && e_post != '0) ? PAD_POST : DONE;
    ld       = idle && bus.start_in;
    run      = ld || state_q inside {PAD_PRE, READ, PAD_POST};
    fin      = run && nxt == DONE;
    iss      = run && !fin && (idle || !bus.stall_in);
    rd       = iss && nxt == READ;
    state_d  = state_q == DONE ? IDLE : fin ? DONE : iss ? nxt : state_q;
    cnt_d    = fin ? '0 : iss ? (more ? cnt_q + 1'b1 : CW'(1)) : cnt_q;
    ptr_a_d  = (run ? e_ptr_a : ptr_a_q) + (rd ? e_stride : '0);
    ptr_b_d  = (run ? e_ptr_b : ptr_b_q) + (rd ? e_stride : '0);
    ena_d    = rd;
    enb_d    = rd && e_dual;
    addra_d  = rd ? {e_bank_a, e_ptr_a} : '0;
    addrb_d  = enb_d ? {e_bank_b, e_ptr_b} : '0;
    pad_d    = iss && nxt != READ;
    busy_d   = run && !fin;
    done_d   = fin;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_a_q  <= '0;
      ptr_b_q  <= '0;
      bank_a_q <= '0;
      bank_b_q <= '0;
      stride_q <= '0;
      dual_q   <= 1'b0;
      len_q    <= '0;
      pre_q    <= '0;
      post_q   <= '0;
      addra_q  <= '0;
      addrb_q  <= '0;
      ena_q    <= 1'b0;
      enb_q    <= 1'b0;
      pad_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_a_q  <= ptr_a_d;
      ptr_b_q  <= ptr_b_d;
      addra_q  <= addra_d;
      addrb_q  <= addrb_d;
      ena_q    <= ena_d;
      enb_q    <= enb_d;
      pad_q    <= pad_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      if (ld) begin
        bank_a_q <= bus.cfg_bank_a_in;
        bank_b_q <= bus.cfg_bank_b_in;
        stride_q <= bus.cfg_stride_in;
        dual_q   <= bus.cfg_dual_in;
        len_q    <= bus.cfg_len_in;
        pre_q    <= bus.cfg_pad_pre_in;
        post_q   <= bus.cfg_pad_post_in;
      end
    end
  end
  // With one-cycle LSU latency the final slot's data lands exactly in the done cycle
  assign bus.CTRL_LDM_addra_out = addra_q;
  assign bus.CTRL_LDM_ena_out   = ena_q;
  assign bus.CTRL_LDM_wea_out   = 1'b0;
  assign bus.CTRL_LDM_addrb_out = addrb_q;
  assign bus.CTRL_LDM_enb_out   = enb_q;
  assign bus.CTRL_LDM_web_out   = 1'b0;
  assign bus.Padding_Read_out   = pad_q;
  assign bus.busy_out           = busy_q;
  assign bus.last_out           = done_q;
  assign bus.done_out           = done_q;
endmodule

// File: tb/tb_ldm_read_agu.sv
// tb_ldm_read_agu: directed vector table plus randomized sequences against a slot-list reference model
module tb_ldm_read_agu;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;
  ldm_read_agu_if bus();
  ldm_read_agu dut (.CLK(CLK), .RST(RST), .bus(bus));
  typedef struct packed {
    logic [1:0] bank_a; logic [5:0] base_a; logic [1:0] bank_b; logic [5:0] base_b;
    logic dual; logic [6:0] len; logic [5:0] stride; logic [2:0] pre; logic [2:0] post;
  } cfg_t;
  typedef struct packed {
    logic busy; logic ena; logic [7:0] addra; logic enb; logic [7:0] addrb;
    logic pad; logic done; logic last; logic wea; logic web;
  } obs_t;
  typedef struct {logic start; logic stall; cfg_t cfg; obs_t exp;} vec_t;
  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  obs_t slots[$];
  function automatic obs_t observe();
    obs_t o;
    o.busy = bus.busy_out; o.ena = bus.CTRL_LDM_ena_out; o.addra = bus.CTRL_LDM_addra_out;
    o.enb = bus.CTRL_LDM_enb_out; o.addrb = bus.CTRL_LDM_addrb_out; o.pad = bus.Padding_Read_out;
    o.done = bus.done_out; o.last = bus.last_out; o.wea = bus.CTRL_LDM_wea_out; o.web = bus.CTRL_LDM_web_out;
    return o;
  endfunction
  function automatic obs_t o_rd(logic [7:0] a, logic eb, logic [7:0] b);
    obs_t o;
    o = '0; o.busy = 1'b1; o.ena = 1'b1; o.addra = a; o.enb = eb; o.addrb = b;
    return o;
  endfunction
  function automatic obs_t o_pad();
    obs_t o;
    o = '0; o.busy = 1'b1; o.pad = 1'b1;
    return o;
  endfunction
  function automatic obs_t o_stall();
    obs_t o;
    o = '0; o.busy = 1'b1;
    return o;
  endfunction
  function automatic obs_t o_done();
    obs_t o;
    o = '0; o.done = 1'b1; o.last = 1'b1;
    return o;
  endfunction
  function automatic obs_t o_idle();
    obs_t o;
    o = '0;
    return o;
  endfunction
  function automatic void add(logic st, logic sl, cfg_t c, obs_t e);
    vec_t v;
    v.start = st; v.stall = sl; v.cfg = c; v.exp = e;
    tbl.push_back(v);
  endfunction
  // Expected slot stream: pre pads, then reads at base + i*stride wrapping in 64 words, then post pads
  function automatic void build(cfg_t c);
    logic [5:0] a, b;
    slots = {};
    for (int i = 0; i < int'(c.pre); i++) slots.push_back(o_pad());
    for (int i = 0; i < int'(c.len); i++) begin
      a = 6'((int'(c.base_a) + i * int'(c.stride)) % 64);
      b = 6'((int'(c.base_b) + i * int'(c.stride)) % 64);
      slots.push_back(o_rd({c.bank_a, a}, c.dual, c.dual ? {c.bank_b, b} : 8'h00));
    end
    for (int i = 0; i < int'(c.post); i++) slots.push_back(o_pad());
  endfunction
  function automatic cfg_t rnd_cfg();
    cfg_t c;
    c.bank_a = 2'($urandom); c.base_a = 6'($urandom); c.bank_b = 2'($urandom); c.base_b = 6'($urandom);
    c.dual = 1'($urandom);
    c.len = ($urandom_range(3) == 0) ? 7'($urandom_range(64)) : 7'($urandom_range(6));
    c.stride = 6'($urandom);
    c.pre = ($urandom_range(2) == 0) ? 3'd0 : 3'($urandom);
    c.post = ($urandom_range(2) == 0) ? 3'd0 : 3'($urandom);
    return c;
  endfunction
  task automatic set_cfg(cfg_t c);
    bus.cfg_bank_a_in = c.bank_a; bus.cfg_base_a_in = c.base_a;
    bus.cfg_bank_b_in = c.bank_b; bus.cfg_base_b_in = c.base_b;
    bus.cfg_dual_in = c.dual; bus.cfg_len_in = c.len; bus.cfg_stride_in = c.stride;
    bus.cfg_pad_pre_in = c.pre; bus.cfg_pad_post_in = c.post;
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(string nm, obs_t e);
    obs_t a;
    a = observe();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask
  // rnd adds stalls, spurious starts and config churn while busy; none may alter the slot stream
  task automatic run_seq(string nm, cfg_t c, bit rnd);
    int k;
    bit sp, fin;
    obs_t e;
    build(c);
    k = 0; sp = 1'b0; fin = 1'b0;
    set_cfg(c);
    bus.start_in = 1'b1;
    bus.stall_in = rnd ? 1'($urandom) : 1'b0;
    step();
    for (int n = 0; n < 300 && !fin; n++) begin
      if (k == slots.size()) begin
        e = o_done(); fin = 1'b1;
      end else if (sp) e = o_stall();
      else begin
        e = slots[k]; k++;
      end
      chk(nm, e);
      sp = rnd && $urandom_range(3) == 0;
      bus.stall_in = sp;
      bus.start_in = rnd && $urandom_range(3) == 0;
      if (rnd) set_cfg(rnd_cfg());
      step();
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done_out want done_out", nm);
    end
    chk({nm, "_idle"}, o_idle());
    bus.start_in = 1'b0;
    bus.stall_in = 1'b0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
  initial begin
    cfg_t c1, c2, c3, c4, c5, c6;
    c1 = '{bank_a: 2'd1, base_a: 6'd10, len: 7'd4, stride: 6'd1, default: '0};
    c2 = '{bank_a: 2'd0, base_a: 6'd62, bank_b: 2'd2, base_b: 6'd0, dual: 1'b1, len: 7'd3, stride: 6'd1, default: '0};
    c3 = '{pre: 3'd2, len: 7'd2, stride: 6'd4, post: 3'd1, default: '0};
    c4 = '{len: 7'd3, stride: 6'd1, default: '0};
    c5 = '0;
    c6 = '{bank_a: 2'd3, len: 7'd8, stride: 6'd1, default: '0};
    set_cfg('0);
    bus.start_in = 1'b0;
    bus.stall_in = 1'b0;
    step(); step();
    chk("reset", o_idle());
    @(negedge CLK) RST = 1'b1;
    step();
    chk("reset_release", o_idle());
    add(1, 0, c1, o_rd(8'h4A, 0, 0)); add(0, 0, c1, o_rd(8'h4B, 0, 0)); add(0, 0, c1, o_rd(8'h4C, 0, 0));
    add(0, 0, c1, o_rd(8'h4D, 0, 0)); add(0, 0, c1, o_done()); add(0, 0, c1, o_idle());
    add(1, 0, c2, o_rd(8'h3E, 1, 8'h80)); add(0, 0, c2, o_rd(8'h3F, 1, 8'h81));
    add(0, 0, c2, o_rd(8'h00, 1, 8'h82)); add(0, 0, c2, o_done()); add(0, 0, c2, o_idle());
    add(1, 0, c3, o_pad()); add(0, 0, c3, o_pad()); add(0, 0, c3, o_rd(8'h00, 0, 0));
    add(0, 0, c3, o_rd(8'h04, 0, 0)); add(0, 0, c3, o_pad()); add(0, 0, c3, o_done()); add(0, 0, c3, o_idle());
    add(1, 0, c4, o_rd(8'h00, 0, 0)); add(0, 1, c4, o_stall()); add(0, 0, c4, o_rd(8'h01, 0, 0));
    add(0, 0, c4, o_rd(8'h02, 0, 0)); add(0, 0, c4, o_done()); add(0, 0, c4, o_idle());
    add(1, 0, c5, o_done()); add(0, 0, c5, o_idle());
    add(1, 0, c1, o_rd(8'h4A, 0, 0)); add(1, 0, c2, o_rd(8'h4B, 0, 0)); add(1, 0, c2, o_rd(8'h4C, 0, 0));
    add(1, 0, c2, o_rd(8'h4D, 0, 0)); add(1, 0, c2, o_done()); add(1, 0, c2, o_idle()); add(0, 0, c2, o_idle());
    add(1, 1, c4, o_rd(8'h00, 0, 0)); add(0, 0, c4, o_rd(8'h01, 0, 0)); add(0, 0, c4, o_rd(8'h02, 0, 0));
    add(0, 0, c4, o_done()); add(0, 0, c4, o_idle());
    for (int i = 0; i < tbl.size(); i++) begin
      bus.start_in = tbl[i].start;
      bus.stall_in = tbl[i].stall;
      set_cfg(tbl[i].cfg);
      step();
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end
    bus.start_in = 1'b0;
    bus.stall_in = 1'b0;
    set_cfg(c6);
    bus.start_in = 1'b1;
    step();
    bus.start_in = 1'b0;
    chk("abort_rd0", o_rd(8'hC0, 0, 0));
    step(); chk("abort_rd1", o_rd(8'hC1, 0, 0));
    step(); chk("abort_rd2", o_rd(8'hC2, 0, 0));
    #3 RST = 1'b0;
    #1 chk("abort_now", o_idle());
    step(); chk("abort_hold0", o_idle());
    step(); chk("abort_hold1", o_idle());
    @(negedge CLK) RST = 1'b1;
    step();
    chk("abort_idle", o_idle());
    run_seq("after_abort", c1, 1'b0);
    for (int i = 0; i < 40; i++) run_seq($sformatf("rnd%0d", i), rnd_cfg(), 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ldm_read_agu.md
# ldm_read_agu

Read address generator for the LSU's controller ports. It replays a programmed read sequence over the four local data memories (LDMs): a base bank, base address, length and stride, with optional leading and trailing padding slots. From that it drives the LSU's CTRL_LDM_* port A/B request lines and Padding_Read every cycle. It sits directly upstream of the LSU, between the sequencer that issues one start per operation and the LSU that returns Pixel_0/Pixel_1 one cycle after each request.

## Interface
Parameters:
- S_LDM_BITS, 2, source-bank select width (4 LDMs)
- LDM_ADDR_BITS, 6, word address width inside one LDM (64 words)
- PAD_BITS, 3, padding-count width

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, asynchronous, active-low
- start_in  in  1  launch pulse; sampled only in IDLE
- stall_in  in  1  freeze request generation while high
- cfg_bank_a_in  in  S_LDM_BITS  port A bank
- cfg_base_a_in  in  LDM_ADDR_BITS  port A first address
- cfg_bank_b_in  in  S_LDM_BITS  port B bank
- cfg_base_b_in  in  LDM_ADDR_BITS  port B first address
- cfg_dual_in  in  1  1 = issue port B in lockstep with A
- cfg_len_in  in  LDM_ADDR_BITS+1  number of real reads, 0..64
- cfg_stride_in  in  LDM_ADDR_BITS  address increment per read, both ports
- cfg_pad_pre_in  in  PAD_BITS  padding slots before first read
- cfg_pad_post_in  in  PAD_BITS  padding slots after last read
- CTRL_LDM_addra_out  out  S_LDM_BITS+LDM_ADDR_BITS  {bank, addr} port A
- CTRL_LDM_ena_out  out  1  port A read enable
- CTRL_LDM_wea_out  out  1  tied 0
- CTRL_LDM_addrb_out  out  S_LDM_BITS+LDM_ADDR_BITS  {bank, addr} port B
- CTRL_LDM_enb_out  out  1  port B read enable
- CTRL_LDM_web_out  out  1  tied 0
- Padding_Read_out  out  1  padding slot; LSU consumer inserts zero
- busy_out  out  1  high from the cycle after an accepted start until done
- last_out  out  1  one-cycle pulse aligned with the LSU data of the final slot (read or pad)
- done_out  out  1  one-cycle pulse, cycle after the final slot issue

## Operation
- States: IDLE, PAD_PRE, READ, PAD_POST, DONE.
- IDLE with start_in=1: latch all cfg_* into internal registers; load the slot counter. Next state is:
  - PAD_PRE if pad_pre>0;
  - else READ if len>0;
  - else PAD_POST if pad_post>0;
  - else DONE.
- Config changes after start do not affect the running sequence. A start in any state other than IDLE is ignored.
- PAD_PRE: each unstalled cycle issues one slot. Padding_Read_out=1, ena=enb=0, addresses 0. Leave after pad_pre slots, using the same precedence as from IDLE (READ, PAD_POST, DONE).
- READ: each unstalled cycle issues one read.
  - addra = {bank_a, ptr_a}, ena=1.
  - If dual: addrb = {bank_b, ptr_b}, enb=1; else enb=0 and addrb=0.
  - After issue: ptr += stride, modulo 2^LDM_ADDR_BITS. Wraps inside the bank; the bank never increments.
  - Leave after len reads, to PAD_POST or DONE.
- PAD_POST: same as PAD_PRE for pad_post slots, then DONE.
- DONE: done_out=1 for one cycle, then IDLE. A start arriving in DONE is ignored.
- stall_in=1 in PAD_PRE/READ/PAD_POST: no slot issued that cycle. ena=enb=Padding_Read=0; pointers, counters and state hold. Stall has no effect in IDLE or DONE.
- wea/web are constant 0; this block never writes.

## Timing
- All outputs are registered. Reset (RST low, async) forces every output to 0, state to IDLE, and pointers/counters to 0. Reset mid-sequence aborts it with no done_out.
- start accepted at edge t: first slot outputs valid in cycle t+1, busy_out=1 from t+1.
- Unstalled sequence length: pad_pre + len + pad_post issue cycles, then one DONE cycle. busy_out drops when done_out rises.
  - Example: pad_pre=1, len=4, pad_post=1 means slots in cycles t+1..t+6, done_out in t+7.
- LSU data latency is 1 cycle, so last_out is asserted the cycle after the final slot issue, i.e. coincident with done_out.
- Total slot count is at most 7+64+7 = 78; the slot counter must be at least 7 bits.
- len=0 with both pads 0: done_out in t+1, no request or padding outputs.
- Back-to-back: start accepted in IDLE at t+8 after a done at t+7. Minimum one IDLE cycle between sequences.

## Test plan
- Single-port sequence:
  - Stimulus: bank_a=1, base_a=10, len=4, stride=1, no pad, dual=0.
  - Required: ena=1 with addra = 0x4A, 0x4B, 0x4C, 0x4D in cycles t+1..t+4; enb=0 throughout; done_out in t+5.
- Dual-port with wrap:
  - Stimulus: bank_a=0, base_a=62, bank_b=2, base_b=0, len=3, stride=1, dual=1.
  - Required: addra = 0x3E, 0x3F, 0x00; addrb = 0x80, 0x81, 0x82.
- Padding:
  - Stimulus: pad_pre=2, len=2, stride=4, base_a=0, pad_post=1.
  - Required: Padding_Read high for t+1 and t+2 with ena=0; reads at addresses 0 and 4 in t+3 and t+4; Padding_Read high in t+5; done_out and last_out in t+6.
- Stall:
  - Stimulus: len=3, stall_in high in cycle t+2 only.
  - Required: reads at addresses 0 in t+1, 1 in t+3, 2 in t+4; ena=0 in t+2; done_out in t+5.
- Degenerate and ignored starts:
  - Stimulus: len=0 with no pads; separately, a second start_in pulse while busy.
  - Required: done_out in t+1 with no enables; the second start has no effect on the addresses or the done timing.
- Reset abort:
  - Stimulus: RST low in the middle of a len=8 sequence.
  - Required: all outputs 0 immediately, no done_out; a new start after reset release runs a full, normal sequence.
